// File: rtl/hex2ascii_ser.sv
// -----------------------------------------------------------------------------
// hex2ascii_ser
// Serialises a DATA_W-bit binary word into ASCII hex characters, most
// significant nibble first, one character per out_valid/out_ready handshake.
//
// Parameters
//   DATA_W    : input word width, multiple of 4, 4..64
//   LOWERCASE : 0 -> 'A'-'F', 1 -> 'a'-'f'
//   APPEND_NL : 1 -> 8'h0A follows the last digit
//
// Optional feature
//   HEX2ASCII_PREFIX_EN : when defined, "0x" precedes the digits
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   in_data/in_valid  : word to convert and its valid
//   in_ready          : high only in IDLE and outside reset
//   out_char/out_valid: registered ASCII character stream
//   out_ready         : sink accepts out_char
//   busy              : high from word acceptance to the last char handshake
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for a word, in_ready high
// PREFIX0 | presenting '0' of the "0x" prefix (prefix build only)
// PREFIX1 | presenting 'x' of the "0x" prefix (prefix build only)
// DIGIT   | presenting hex digits, r_cnt = digits left incl. current
// TERM    | presenting the line-feed terminator
// -----------------------------------------------------------------------------
module hex2ascii_ser #(
  parameter int DATA_W    = 32,
  parameter int LOWERCASE = 0,
  parameter int APPEND_NL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int NCH   = DATA_W / 4;
  localparam int CNT_W = $clog2(NCH + 1);
  localparam logic [7:0] ALPHA_OFS = (LOWERCASE != 0) ? 8'd87 : 8'd55;

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef HEX2ASCII_PREFIX_EN
    S_PREFIX0,
    S_PREFIX1,
`endif
    S_DIGIT,
    S_TERM
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_out_char;
  logic              r_out_valid;
  logic              r_busy;

  logic              w_hs;
  logic [3:0]        w_next_nib;

  function automatic logic [7:0] f_hex(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h0, nib} + 8'd48;
    else             return {4'h0, nib} + ALPHA_OFS;
  endfunction

  assign w_hs      = r_out_valid && out_ready;
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_char  = r_out_char;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;

  // Nibble that moves to the top once the current digit completes.
  generate
    if (NCH > 1) begin : g_next_nib
      assign w_next_nib = r_shreg[DATA_W-5 -: 4];
    end else begin : g_single_nib
      assign w_next_nib = 4'h0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shreg     <= '0;
      r_cnt       <= '0;
      r_out_char  <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shreg     <= in_data;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b1;
`ifdef HEX2ASCII_PREFIX_EN
            r_out_char  <= 8'h30;
            r_state     <= S_PREFIX0;
`else
            r_out_char  <= f_hex(in_data[DATA_W-1 -: 4]);
            r_cnt       <= CNT_W'(NCH);
            r_state     <= S_DIGIT;
`endif
          end
        end
`ifdef HEX2ASCII_PREFIX_EN
        S_PREFIX0: begin
          if (w_hs) begin
            // 'x' is lowercase independent of LOWERCASE
            r_out_char <= 8'h78;
            r_state    <= S_PREFIX1;
          end
        end
        S_PREFIX1: begin
          if (w_hs) begin
            r_out_char <= f_hex(r_shreg[DATA_W-1 -: 4]);
            r_cnt      <= CNT_W'(NCH);
            r_state    <= S_DIGIT;
          end
        end
`endif
        S_DIGIT: begin
          if (w_hs) begin
            if (r_cnt == CNT_W'(1)) begin
              r_cnt <= '0;
              if (APPEND_NL != 0) begin
                r_out_char <= 8'h0A;
                r_state    <= S_TERM;
              end else begin
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
                r_state     <= S_IDLE;
              end
            end else begin
              r_cnt      <= r_cnt - CNT_W'(1);
              r_shreg    <= r_shreg << 4;
              r_out_char <= f_hex(w_next_nib);
            end
          end
        end
        S_TERM: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex2ascii_ser.sv
module tb_hex2ascii_ser;

  logic        clk;
  logic        rst;
  logic        ordy;
  logic        vld [4];
  logic [15:0] din_a;
  logic [15:0] din_b;
  logic [7:0]  din_c;
  logic [7:0]  din_d;
  logic [7:0]  oc  [4];
  logic        ov  [4];
  logic        ir  [4];
  logic        bz  [4];

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] exp_q [$];

  // 0: 16b upper, NL   1: 16b lower, NL   2: 8b upper, NL   3: 8b upper, no NL
  hex2ascii_ser #(.DATA_W(16), .LOWERCASE(0), .APPEND_NL(1)) u_dut_a (
    .clk(clk), .rst(rst), .in_data(din_a), .in_valid(vld[0]), .in_ready(ir[0]),
    .out_char(oc[0]), .out_valid(ov[0]), .out_ready(ordy), .busy(bz[0]));
  hex2ascii_ser #(.DATA_W(16), .LOWERCASE(1), .APPEND_NL(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(din_b), .in_valid(vld[1]), .in_ready(ir[1]),
    .out_char(oc[1]), .out_valid(ov[1]), .out_ready(ordy), .busy(bz[1]));
  hex2ascii_ser #(.DATA_W(8), .LOWERCASE(0), .APPEND_NL(1)) u_dut_c (
    .clk(clk), .rst(rst), .in_data(din_c), .in_valid(vld[2]), .in_ready(ir[2]),
    .out_char(oc[2]), .out_valid(ov[2]), .out_ready(ordy), .busy(bz[2]));
  hex2ascii_ser #(.DATA_W(8), .LOWERCASE(0), .APPEND_NL(0)) u_dut_d (
    .clk(clk), .rst(rst), .in_data(din_d), .in_valid(vld[3]), .in_ready(ir[3]),
    .out_char(oc[3]), .out_valid(ov[3]), .out_ready(ordy), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int              inst;
    logic [15:0]     data;
    int              n;
    logic [5:0][7:0] ch;   // ch[5] is the first expected digit
  } vec_t;

  vec_t vecs [7];

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b", name, act, exp);
  endtask

  task automatic chk_c(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic set_data(input int idx, input logic [15:0] d);
    case (idx)
      0: din_a = d;
      1: din_b = d;
      2: din_c = d[7:0];
      default: din_d = d[7:0];
    endcase
  endtask

  task automatic load_exp(input int n, input logic [5:0][7:0] ch);
    exp_q.delete();
`ifdef HEX2ASCII_PREFIX_EN
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h78);
`endif
    for (int k = 0; k < n; k++) exp_q.push_back(ch[5-k]);
  endtask

  // Entered and left at a negative edge; out_ready assumed high.
  task automatic run_word(input int idx, input logic [15:0] data, input string tag);
    chk_b($sformatf("%s in_ready_before", tag), ir[idx], 1'b1);
    set_data(idx, data);
    vld[idx] = 1'b1;
    @(posedge clk);
    #1 vld[idx] = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      chk_b($sformatf("%s valid[%0d]", tag, k), ov[idx], 1'b1);
      chk_c($sformatf("%s char[%0d]", tag, k), oc[idx], exp_q[k]);
      chk_b($sformatf("%s busy[%0d]", tag, k), bz[idx], 1'b1);
      chk_b($sformatf("%s in_ready_busy[%0d]", tag, k), ir[idx], 1'b0);
    end
    @(negedge clk);
    chk_b($sformatf("%s valid_end", tag), ov[idx], 1'b0);
    chk_b($sformatf("%s busy_end", tag), bz[idx], 1'b0);
    chk_b($sformatf("%s in_ready_end", tag), ir[idx], 1'b1);
  endtask

  logic [5:0][7:0] wexp [3];
  logic [15:0]     wdat [3];
  int              bp;

  initial begin
    rst = 1'b1;
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    din_a = '0; din_b = '0; din_c = '0; din_d = '0;

    vecs[0] = '{0, 16'h1A2F, 5, {8'h31, 8'h41, 8'h32, 8'h46, 8'h0A, 8'h00}};
    vecs[1] = '{0, 16'h0000, 5, {8'h30, 8'h30, 8'h30, 8'h30, 8'h0A, 8'h00}};
    vecs[2] = '{0, 16'hFFFF, 5, {8'h46, 8'h46, 8'h46, 8'h46, 8'h0A, 8'h00}};
    vecs[3] = '{1, 16'hBEEF, 5, {8'h62, 8'h65, 8'h65, 8'h66, 8'h0A, 8'h00}};
    vecs[4] = '{1, 16'h09AF, 5, {8'h30, 8'h39, 8'h61, 8'h66, 8'h0A, 8'h00}};
    vecs[5] = '{3, 16'h00F0, 2, {8'h46, 8'h30, 8'h00, 8'h00, 8'h00, 8'h00}};
    vecs[6] = '{2, 16'h005C, 3, {8'h35, 8'h43, 8'h0A, 8'h00, 8'h00, 8'h00}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk_b($sformatf("rst valid%0d", i), ov[i], 1'b0);
      chk_c($sformatf("rst char%0d", i), oc[i], 8'h00);
      chk_b($sformatf("rst busy%0d", i), bz[i], 1'b0);
      chk_b($sformatf("rst in_ready%0d", i), ir[i], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk_b($sformatf("post_rst in_ready%0d", i), ir[i], 1'b1);

    // Table-driven words
    for (int v = 0; v < 7; v++) begin
      load_exp(vecs[v].n, vecs[v].ch);
      run_word(vecs[v].inst, vecs[v].data, $sformatf("vec%0d", v));
    end

    // Backpressure on the second digit, with in_valid pulsed meanwhile
    load_exp(5, vecs[0].ch);
    bp = exp_q.size() - 4;
    set_data(0, 16'h1A2F);
    vld[0] = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      if (k == bp) begin
        ordy = 1'b0;
        vld[0] = 1'b1;
        set_data(0, 16'hFFFF);
        for (int h = 0; h < 3; h++) begin
          chk_b($sformatf("bp hold_valid%0d", h), ov[0], 1'b1);
          chk_c($sformatf("bp hold_char%0d", h), oc[0], exp_q[k]);
          chk_b($sformatf("bp in_ready%0d", h), ir[0], 1'b0);
          @(negedge clk);
        end
        ordy = 1'b1;
        vld[0] = 1'b0;
      end
      chk_b($sformatf("bp valid[%0d]", k), ov[0], 1'b1);
      chk_c($sformatf("bp char[%0d]", k), oc[0], exp_q[k]);
    end
    @(negedge clk);
    chk_b("bp valid_end", ov[0], 1'b0);
    chk_b("bp in_ready_end", ir[0], 1'b1);
    @(negedge clk);
    chk_b("bp no_extra_word", ov[0], 1'b0);
    chk_b("bp busy_idle", bz[0], 1'b0);

    // Reset after the second character handshake
    load_exp(5, vecs[0].ch);
    set_data(0, 16'h1A2F);
    vld[0] = 1'b1;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    @(negedge clk);
    chk_c("mid_rst char0", oc[0], exp_q[0]);
    @(negedge clk);
    chk_c("mid_rst char1", oc[0], exp_q[1]);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_b("mid_rst in_ready_in_rst", ir[0], 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_b("mid_rst valid", ov[0], 1'b0);
    chk_b("mid_rst busy", bz[0], 1'b0);
    chk_b("mid_rst in_ready", ir[0], 1'b1);
    chk_c("mid_rst char", oc[0], 8'h00);
    load_exp(vecs[1].n, vecs[1].ch);
    run_word(0, 16'h0000, "after_rst");

    // Back-to-back words with in_valid held high
    wdat[0] = 16'h005C; wexp[0] = {8'h35, 8'h43, 8'h0A, 8'h00, 8'h00, 8'h00};
    wdat[1] = 16'h00A3; wexp[1] = {8'h41, 8'h33, 8'h0A, 8'h00, 8'h00, 8'h00};
    wdat[2] = 16'h0007; wexp[2] = {8'h30, 8'h37, 8'h0A, 8'h00, 8'h00, 8'h00};
    set_data(2, wdat[0]);
    vld[2] = 1'b1;
    for (int w = 0; w < 3; w++) begin
      load_exp(3, wexp[w]);
      @(posedge clk);
      #1;
      if (w < 2) set_data(2, wdat[w+1]);
      else       vld[2] = 1'b0;
      for (int k = 0; k < exp_q.size(); k++) begin
        @(negedge clk);
        chk_b($sformatf("b2b w%0d valid[%0d]", w, k), ov[2], 1'b1);
        chk_c($sformatf("b2b w%0d char[%0d]", w, k), oc[2], exp_q[k]);
      end
      @(negedge clk);
      chk_b($sformatf("b2b w%0d idle_valid", w), ov[2], 1'b0);
      chk_b($sformatf("b2b w%0d idle_busy", w), bz[2], 1'b0);
      chk_b($sformatf("b2b w%0d idle_in_ready", w), ir[2], 1'b1);
    end
    @(negedge clk);
    chk_b("b2b no_extra_word", ov[2], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hex2ascii_ser.md
Name: hex2ascii_ser

Overview:
Serialises a DATA_W-bit binary word into a stream of ASCII hex characters, one character per handshake, most significant nibble first.
- Optionally emits a lowercase alphabet, a trailing line-feed terminator, and a "0x" prefix.
- Sits between debug/telemetry sources and a UART TX or trace FIFO.
- Uses valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, input word width in bits; must be a multiple of 4, min 4, max 64
LOWERCASE, 0, 0: digits A-F emitted as 0x41-0x46; 1: a-f emitted as 0x61-0x66
APPEND_NL, 1, 1: emit 8'h0A after the last digit; 0: no terminator

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous active-high reset
in_data  in  DATA_W  binary word to convert
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a word
out_char  out  8  ASCII character
out_valid  out  1  out_char valid
out_ready  in  1  sink accepts out_char
busy  out  1  high from word acceptance until the last character handshake completes

Behaviour:
Reset and handshakes
- Reset (rst high at clk edge): state=IDLE, out_valid=0, out_char=8'h00, busy=0, nibble counter=0. Input handshakes are ignored while rst is high.
- in_ready = (state==IDLE) && !rst. This is combinational from state only, with no path from out_ready.
- Accept: in_valid && in_ready at a clk edge latches in_data into a shift register, sets busy=1 and leaves IDLE.
- Next cycle: out_valid=1 with the first character, so latency from accept to first char is 1 clk.
- A character completes on out_valid && out_ready. The next character is presented the following cycle, or the same edge it is registered, giving 1 char/clk under no backpressure.
- While out_valid && !out_ready: out_char and out_valid are held stable.

FSM
- IDLE -> (PREFIX0 -> PREFIX1, macro only) -> DIGIT (NCH=DATA_W/4 chars) -> TERM (APPEND_NL=1 only) -> IDLE.
- DIGIT order: nibble [DATA_W-1:DATA_W-4] first, [3:0] last. Tracked by a down-counter sized $clog2(NCH+1); shift the register left by 4 per completed digit.
- Conversion: nibble<10 -> nibble+8'd48. Otherwise nibble+8'd55 (LOWERCASE=0) or nibble+8'd87 (LOWERCASE=1). All arithmetic is in 8 bits; no overflow is possible.
- On the last character's handshake: out_valid=0, busy=0, state=IDLE at the same edge; in_ready rises the following cycle.
- Throughput: one word per (total chars + 1) clk minimum.

Boundary cases
- DATA_W=4: single digit.
- All-zero word: emits all '0' digits; no leading-zero suppression.
- Reset mid-word: the stream is aborted immediately, with no terminator. out_valid=0 on the next cycle and the partial word is discarded.
- in_valid asserted while busy: ignored, because in_ready=0; in_data is not sampled.

Optional Feature:
Macro: HEX2ASCII_PREFIX_EN
- Defined: two extra characters, 8'h30 ('0') then 8'h78 ('x'), precede the digits. States PREFIX0/PREFIX1 are compiled in and the total char count is NCH+2+APPEND_NL. The prefix 'x' is always lowercase regardless of LOWERCASE.
- Undefined: prefix states and logic are absent and the first character is the MS digit.

Test Plan:
1. DATA_W=16, LOWERCASE=0, APPEND_NL=1, out_ready=1: in_data=16'h1A2F accepted -> out_char 0x31,0x41,0x32,0x46,0x0A on 5 consecutive cycles starting 1 clk after accept; in_ready high again 1 clk after the 0x0A handshake.
2. Same config with LOWERCASE=1, in_data=16'hBEEF -> 0x62,0x65,0x65,0x66,0x0A.
3. Backpressure: 16'h1A2F with out_ready low for 3 cycles while 0x41 is presented -> out_char holds 0x41 with out_valid=1 for all 3 cycles, then 0x32 follows; in_valid pulsed during this time is not accepted.
4. Reset mid-stream: assert rst for 1 clk after the 2nd char handshake -> out_valid=0, busy=0, in_ready=1 after rst deasserts; next word 16'h0000 gives 0x30 x4 then 0x0A.
5. HEX2ASCII_PREFIX_EN defined, DATA_W=8, APPEND_NL=0, in_data=8'hF0 -> 0x30,0x78,0x46,0x30, with busy low after the 4th handshake.
6. Back-to-back words with in_valid held high and DATA_W=8 -> each word yields exactly 3 chars with one idle cycle (out_valid=0) between words; no char is duplicated or dropped.
